// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: per-requester result record and the broadcast packet.
package cdb_arbiter_pkg;

  localparam int NUM_FU_ALU  = 2;
  localparam int NUM_FU_MULT = 1;
  localparam int NUM_FU_LOAD = 1;
  localparam int NUM_CDB_REQ = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
  localparam int CDB_N       = 2;
  localparam int PRN_W       = 6;
  localparam int ROB_W       = 5;

  typedef struct packed {
    logic [31:0]      value;
    logic [PRN_W-1:0] dest_prn;
    logic [ROB_W-1:0] robn;
  } cdb_req_t;

  typedef struct packed {
    logic             valid;
    logic [PRN_W-1:0] dest_prn;
    logic [31:0]      value;
    logic [ROB_W-1:0] robn;
  } cdb_packet_t;

  localparam int REQ_W = $bits(cdb_req_t);
  localparam int PKT_W = $bits(cdb_packet_t);

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Rotating-priority selector: grants the first CDB_W set requests scanning
// circularly from ptr; grant k lands in gnt_bus[k].
module cdb_rr_select #(
  parameter int NUM_REQ = 4,
  parameter int CDB_W   = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [PTR_W-1:0]                ptr,
  output logic [CDB_W-1:0][NUM_REQ-1:0]   gnt_bus,
  output logic [PTR_W-1:0]                last_idx,
  output logic                            any_gnt
);

  localparam int              IDX_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] NREQ = IDX_W'(NUM_REQ);

  logic [IDX_W-1:0] pos;
  int               taken;

  // Walking the rotated order j = 0.. is the priority encoder on req rotated
  // by ptr; pos maps each rotated position back to the physical requester.
  always_comb begin
    gnt_bus  = '0;
    last_idx = ptr;
    any_gnt  = 1'b0;
    taken    = 0;
    pos      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      pos = {1'b0, ptr} + IDX_W'(j);
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos[PTR_W-1:0]] && (taken < CDB_W)) begin
        for (int k = 0; k < CDB_W; k++)
          if (taken == k) gnt_bus[k][pos[PTR_W-1:0]] = 1'b1;
        last_idx = pos[PTR_W-1:0];
        any_gnt  = 1'b1;
        taken    = taken + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin multi-grant of finished FU results onto CDB_W
// registered broadcast slots, with squash and synchronous reset.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  parameter int CDB_W   = CDB_N,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*REQ_W-1:0] req_packet,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [CDB_W*PKT_W-1:0]   cdb_packet,
  output logic [PTR_W-1:0]         rr_ptr_out
);

  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]               rr_ptr;
  logic [CDB_W-1:0][NUM_REQ-1:0]  gnt_bus;
  logic [PTR_W-1:0]               last_idx;
  logic                           any_gnt;
  logic [NUM_REQ-1:0]             ack_raw;
  logic [CDB_W-1:0]               vld_p0;
  logic [REQ_W-1:0]               acc;
  cdb_req_t                       sel_p0 [CDB_W];
  cdb_packet_t                    pkt_p1 [CDB_W];

  cdb_rr_select #(
    .NUM_REQ (NUM_REQ),
    .CDB_W   (CDB_W),
    .PTR_W   (PTR_W)
  ) u_select (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .gnt_bus  (gnt_bus),
    .last_idx (last_idx),
    .any_gnt  (any_gnt)
  );

  // Stage p0: grant decode and one-hot OR-mux of the granted results.
  always_comb begin
    ack_raw = '0;
    acc     = '0;
    for (int k = 0; k < CDB_W; k++) begin
      ack_raw   = ack_raw | gnt_bus[k];
      vld_p0[k] = !squash && (|gnt_bus[k]);
      acc       = '0;
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt_bus[k][i]) acc = acc | req_packet[i*REQ_W +: REQ_W];
      sel_p0[k] = acc;
    end
  end

  assign req_ack = (reset || squash) ? '0 : ack_raw;

  // Stage p1: broadcast registers; idle slots keep their stale fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < CDB_W; k++) pkt_p1[k] <= '0;
      rr_ptr <= '0;
    end else begin
      for (int k = 0; k < CDB_W; k++) begin
        pkt_p1[k].valid <= vld_p0[k];
        if (vld_p0[k]) begin
          pkt_p1[k].dest_prn <= sel_p0[k].dest_prn;
          pkt_p1[k].value    <= sel_p0[k].value;
          pkt_p1[k].robn     <= sel_p0[k].robn;
        end
      end
      if (squash)
        rr_ptr <= '0;
      else if (any_gnt)
        rr_ptr <= (last_idx == LAST_REQ) ? '0 : last_idx + PTR_W'(1);
    end
  end

  for (genvar k = 0; k < CDB_W; k++) begin : g_out
    assign cdb_packet[k*PKT_W +: PKT_W] = pkt_p1[k];
  end

  assign rr_ptr_out = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter with NUM_REQ=4, CDB_W=2.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int CW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  logic [NR-1:0]     req_valid;
  logic [NR*REQ_W-1:0] req_packet;
  logic [NR-1:0]     req_ack;
  logic [CW*PKT_W-1:0] cdb_packet;
  logic [1:0]        rr_ptr_out;

  cdb_arbiter #(.NUM_REQ(NR), .CDB_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .req_valid  (req_valid),
    .req_packet (req_packet),
    .req_ack    (req_ack),
    .cdb_packet (cdb_packet),
    .rr_ptr_out (rr_ptr_out)
  );

  always #5 clock = ~clock;

  // Requesters 2 and 3 deliberately share dest_prn 10.
  logic [31:0]      d_val [NR] = '{32'h55, 32'hA1, 32'hB2, 32'hC3};
  logic [PRN_W-1:0] d_prn [NR] = '{6'd7, 6'd9, 6'd10, 6'd10};
  logic [ROB_W-1:0] d_rob [NR] = '{5'd3, 5'd4, 5'd5, 5'd6};

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] vld;
    int         s0;
    int         s1;
    logic [1:0] ptr;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cdb_packet_t slot(input int k);
    return cdb_packet_t'(cdb_packet[k*PKT_W +: PKT_W]);
  endfunction

  function automatic cdb_packet_t exp_pkt(input int idx);
    return '{valid: 1'b1, dest_prn: d_prn[idx], value: d_val[idx], robn: d_rob[idx]};
  endfunction

  task automatic check_slot(input string name, input int k, input logic v, input int idx);
    if (v) check(name, 64'(slot(k)), 64'(exp_pkt(idx)));
    else   check(name, 64'(slot(k).valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; squash = 1'b0; req_valid = '0;
    for (int i = 0; i < NR; i++)
      req_packet[i*REQ_W +: REQ_W] = cdb_req_t'{d_val[i], d_prn[i], d_rob[i]};

    vt[0]  = '{4'b0001, 4'b0001, 2'b01, 0, 0, 2'd1};
    vt[1]  = '{4'b1000, 4'b1000, 2'b01, 3, 0, 2'd0};
    vt[2]  = '{4'b1111, 4'b0011, 2'b11, 0, 1, 2'd2};
    vt[3]  = '{4'b1111, 4'b1100, 2'b11, 2, 3, 2'd0};
    vt[4]  = '{4'b1111, 4'b0011, 2'b11, 0, 1, 2'd2};
    vt[5]  = '{4'b1111, 4'b1100, 2'b11, 2, 3, 2'd0};
    vt[6]  = '{4'b0000, 4'b0000, 2'b00, 0, 0, 2'd0};
    vt[7]  = '{4'b0100, 4'b0100, 2'b01, 2, 0, 2'd3};
    vt[8]  = '{4'b1001, 4'b1001, 2'b11, 3, 0, 2'd1};
    vt[9]  = '{4'b0110, 4'b0110, 2'b11, 1, 2, 2'd3};
    vt[10] = '{4'b0011, 4'b0011, 2'b11, 0, 1, 2'd2};

    // Reset held with no requests.
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check($sformatf("rst%0d ack", c), 64'(req_ack), 64'd0);
      check($sformatf("rst%0d slot0", c), 64'(slot(0)), 64'd0);
      check($sformatf("rst%0d slot1", c), 64'(slot(1)), 64'd0);
      check($sformatf("rst%0d ptr", c), 64'(rr_ptr_out), 64'd0);
    end
    @(negedge clock); req_valid = 4'b1111; #1;
    check("rst ack with req", 64'(req_ack), 64'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      reset = 1'b0; squash = 1'b0; req_valid = vt[i].req; #1;
      check($sformatf("vec%0d ack", i), 64'(req_ack), 64'(vt[i].ack));
      @(posedge clock); #1;
      check_slot($sformatf("vec%0d slot0", i), 0, vt[i].vld[0], vt[i].s0);
      check_slot($sformatf("vec%0d slot1", i), 1, vt[i].vld[1], vt[i].s1);
      check($sformatf("vec%0d ptr", i), 64'(rr_ptr_out), 64'(vt[i].ptr));
    end

    // Squash: no acks, in-flight broadcast stays, pointer cleared.
    @(negedge clock); squash = 1'b1; req_valid = 4'b1111; #1;
    check("sq ack", 64'(req_ack), 64'd0);
    check("sq inflight slot0", 64'(slot(0)), 64'(exp_pkt(0)));
    @(posedge clock); #1;
    check("sq slot0 vld", 64'(slot(0).valid), 64'd0);
    check("sq slot1 vld", 64'(slot(1).valid), 64'd0);
    check("sq ptr", 64'(rr_ptr_out), 64'd0);

    // Load one result, then reset+squash with pending requests.
    @(negedge clock); squash = 1'b0; req_valid = 4'b0010; #1;
    check("pre ack", 64'(req_ack), 64'b0010);
    @(posedge clock); #1;
    check_slot("pre slot0", 0, 1'b1, 1);
    check("pre ptr", 64'(rr_ptr_out), 64'd2);
    @(negedge clock); reset = 1'b1; squash = 1'b1; req_valid = 4'b1111; #1;
    check("rs ack", 64'(req_ack), 64'd0);
    @(posedge clock); #1;
    check("rs slot0", 64'(slot(0)), 64'd0);
    check("rs slot1", 64'(slot(1)), 64'd0);
    check("rs ptr", 64'(rr_ptr_out), 64'd0);
    @(negedge clock); reset = 1'b0; squash = 1'b0; req_valid = 4'b0100; #1;
    check("re ack", 64'(req_ack), 64'b0100);
    @(posedge clock); #1;
    check_slot("re slot0", 0, 1'b1, 2);
    check_slot("re slot1", 1, 1'b0, 0);
    check("re ptr", 64'(rr_ptr_out), 64'd3);

    @(negedge clock); req_valid = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
